// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and default widths for the memory request sequencer.
package mem_seq_pkg;
    localparam int MEM_WIDTH = 32;
    localparam int MEM_ADDRESS = 4;
    typedef struct packed {
        logic                   write;
        logic [MEM_ADDRESS-1:0] address;
        logic [MEM_WIDTH-1:0]   data;
    } req_t;
    typedef struct packed {
        logic [MEM_ADDRESS-1:0] address;
        logic [MEM_WIDTH-1:0]   data;
    } rsp_t;
endpackage

// File: rtl/mem_req_sequencer_fifo.sv
// sync_fifo: synchronous FIFO with registered occupancy count.
// Ports: clk/rst (sync, active-high), push/din, pop/dout (head, show-ahead),
// full/empty/count. Push while full and pop while empty are ignored.
module sync_fifo #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(D+1)-1:0] count
);
    localparam int AW = D > 1 ? $clog2(D) : 1;
    localparam int CW = $clog2(D + 1);
    logic [W-1:0]  mem [D];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;
    assign full = count == CW'(D);
    assign empty = count == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rp];
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wp] <= din;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (do_push)
                wp <= wp == AW'(D - 1) ? '0 : wp + 1'b1;
            if (do_pop)
                rp <= rp == AW'(D - 1) ? '0 : rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: buffers client read/write requests and issues them in order
// to a single-port memory, returning read data tagged with its address.
// Ports: req_* client request handshake; in_data/address/wr_en/rd_en registered
// memory command; out_data/valid_out memory read return; rsp_* response
// handshake; idle when nothing is queued, in flight or buffered;
// err_unexpected sticky flag for read data arriving with no read pending.
module mem_req_sequencer
    import mem_seq_pkg::*;
#(
    parameter int WIDTH = MEM_WIDTH,
    parameter int DEPTH = 16,
    parameter int ADDRESS = $clog2(DEPTH),
    parameter int REQ_DEPTH = 4,
    parameter int RSP_CREDITS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [ADDRESS-1:0] req_address,
    input  logic [WIDTH-1:0]   req_data,
    output logic [WIDTH-1:0]   in_data,
    output logic [ADDRESS-1:0] address,
    output logic               wr_en,
    output logic               rd_en,
    input  logic [WIDTH-1:0]   out_data,
    input  logic               valid_out,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic [ADDRESS-1:0] rsp_address,
    output logic               idle,
    output logic               err_unexpected
);
    localparam int RW = 1 + ADDRESS + WIDTH;
    localparam int PW = ADDRESS + WIDTH;
    localparam int CW = $clog2(RSP_CREDITS + 1);
    logic [RW-1:0]                    req_dout;
    logic                             req_full;
    logic                             req_empty;
    logic [$clog2(REQ_DEPTH+1)-1:0]   req_cnt;
    logic [ADDRESS-1:0]               pend_dout;
    logic                             pend_full;
    logic                             pend_empty;
    logic [$clog2(RSP_CREDITS+1)-1:0] pend_cnt;
    logic [PW-1:0]                    rsp_dout;
    logic                             rsp_full;
    logic                             rsp_empty;
    logic [$clog2(RSP_CREDITS+1)-1:0] rsp_cnt;
    logic                             h_write;
    logic [ADDRESS-1:0]               h_address;
    logic [WIDTH-1:0]                 h_data;
    logic                             rsp_pop;
    logic                             issue;
    logic                             issue_rd;
    logic [CW-1:0]                    credits;
    logic                             cap_valid;
    logic [WIDTH-1:0]                 cap_data;
    logic                             after_rst;
    assign req_ready = !req_full;
    assign h_write = req_dout[RW-1];
    assign h_address = req_dout[RW-2 -: ADDRESS];
    assign h_data = req_dout[WIDTH-1:0];
    assign rsp_valid = !rsp_empty;
    assign rsp_pop = rsp_valid && rsp_ready;
    // A credit returned by a response pop on this edge can be spent by a read
    // issuing on the same edge.
    assign issue = !req_empty && (h_write || credits != '0 || rsp_pop);
    assign issue_rd = issue && !h_write;
    assign rsp_address = rsp_valid ? rsp_dout[PW-1 -: ADDRESS] : '0;
    assign rsp_data = rsp_valid ? rsp_dout[WIDTH-1:0] : '0;
    assign idle = req_cnt == '0 && pend_cnt == '0 && rsp_cnt == '0;
    sync_fifo #(.W(RW), .D(REQ_DEPTH)) u_req_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_valid && req_ready),
        .pop   (issue),
        .din   ({req_write, req_address, req_data}),
        .dout  (req_dout),
        .full  (req_full),
        .empty (req_empty),
        .count (req_cnt)
    );
    sync_fifo #(.W(ADDRESS), .D(RSP_CREDITS)) u_pend_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (issue_rd && !pend_full),
        .pop   (cap_valid),
        .din   (h_address),
        .dout  (pend_dout),
        .full  (pend_full),
        .empty (pend_empty),
        .count (pend_cnt)
    );
    sync_fifo #(.W(PW), .D(RSP_CREDITS)) u_rsp_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (cap_valid && !pend_empty && !rsp_full),
        .pop   (rsp_pop),
        .din   ({pend_dout, cap_data}),
        .dout  (rsp_dout),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_cnt)
    );
    // Read data is registered before it meets the pending FIFO; after_rst masks
    // the return of a read that was issued just before reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en <= 1'b0;
            rd_en <= 1'b0;
            in_data <= '0;
            address <= '0;
            credits <= CW'(RSP_CREDITS);
            cap_valid <= 1'b0;
            cap_data <= '0;
            after_rst <= 1'b1;
            err_unexpected <= 1'b0;
        end else begin
            wr_en <= issue && h_write;
            rd_en <= issue_rd;
            if (issue)
                address <= h_address;
            if (issue && h_write)
                in_data <= h_data;
            credits <= credits - CW'(issue_rd) + CW'(rsp_pop);
            cap_valid <= valid_out && !after_rst;
            cap_data <= out_data;
            after_rst <= 1'b0;
            if (cap_valid && pend_empty)
                err_unexpected <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb_mem_req_sequencer: randomized and directed bench with an in-order scoreboard and memory model.
module tb_mem_req_sequencer;
    import mem_seq_pkg::*;
    localparam int REQ_DEPTH = 4;
    localparam int RSP_CREDITS = 2;
    typedef struct {
        rsp_t r;
        int   due;
    } exp_rsp_t;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [3:0]  req_address;
    logic [31:0] req_data;
    logic [31:0] in_data;
    logic [3:0]  address;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] out_data;
    logic        valid_out;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_address;
    logic        idle;
    logic        err_unexpected;
    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    int          outstanding = 0;
    int          rd_pulses = 0;
    int          err_due = 0;
    bit          err_m = 0;
    bit          force_vo = 0;
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    logic        p_wr = 0;
    logic        p_rd = 0;
    logic [3:0]  p_addr = 0;
    logic [31:0] p_din = 0;
    req_t        acc_q [$];
    rsp_t        rdq [$];
    exp_rsp_t    rspq [$];
    always #5 clk = ~clk;
    mem_req_sequencer #(
        .WIDTH(32), .DEPTH(16), .ADDRESS(4), .REQ_DEPTH(REQ_DEPTH), .RSP_CREDITS(RSP_CREDITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_write      (req_write),
        .req_address    (req_address),
        .req_data       (req_data),
        .in_data        (in_data),
        .address        (address),
        .wr_en          (wr_en),
        .rd_en          (rd_en),
        .out_data       (out_data),
        .valid_out      (valid_out),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_address    (rsp_address),
        .idle           (idle),
        .err_unexpected (err_unexpected)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    task automatic step();
        bit       acc;
        bit       pop;
        bit       was_rst;
        bit       exp_iss;
        bit       exp_rv;
        req_t     head;
        exp_rsp_t e;
        acc = req_valid && req_ready;
        pop = rsp_valid && rsp_ready;
        was_rst = rst;
        head = '0;
        if (acc_q.size() > 0)
            head = acc_q[0];
        exp_iss = !rst && acc_q.size() > 0 && (head.write || outstanding < RSP_CREDITS || pop);
        @(posedge clk);
        #1;
        cyc++;
        valid_out = p_rd || force_vo;
        out_data = p_rd ? mem[p_addr] : $urandom;
        if (p_wr)
            mem[p_addr] = p_din;
        if (force_vo)
            err_due = cyc + 2;
        force_vo = 0;
        p_wr = wr_en;
        p_rd = rd_en;
        p_addr = address;
        p_din = in_data;
        if (rd_en)
            rd_pulses++;
        if (was_rst) begin
            acc_q.delete();
            rdq.delete();
            rspq.delete();
            outstanding = 0;
            err_m = 0;
            err_due = 0;
            ref_mem = mem;
        end else begin
            check("issue", wr_en | rd_en, exp_iss);
            if (exp_iss) begin
                check("kind", wr_en, head.write);
                check("mem_addr", address, head.address);
                if (head.write)
                    check("wdata", in_data, head.data);
                else if (rdq.size() > 0) begin
                    e.r = rdq.pop_front();
                    e.due = cyc + 3;
                    rspq.push_back(e);
                    outstanding++;
                end
                void'(acc_q.pop_front());
            end
            if (acc) begin
                acc_q.push_back('{req_write, req_address, req_data});
                if (req_write)
                    ref_mem[req_address] = req_data;
                else
                    rdq.push_back('{req_address, ref_mem[req_address]});
            end
            if (pop && rspq.size() > 0) begin
                void'(rspq.pop_front());
                outstanding--;
            end
            if (err_due != 0 && cyc >= err_due)
                err_m = 1;
        end
        check("no_both", wr_en & rd_en, 0);
        check("req_ready", req_ready, acc_q.size() < REQ_DEPTH);
        exp_rv = rspq.size() > 0 && rspq[0].due <= cyc;
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_addr", rsp_address, rspq[0].r.address);
            check("rsp_data", rsp_data, rspq[0].r.data);
        end
        check("idle", idle, acc_q.size() == 0 && outstanding == 0);
        check("err", err_unexpected, err_m);
    endtask
    task automatic send(input bit w, input logic [3:0] a, input logic [31:0] d);
        int n = 0;
        req_valid = 1;
        req_write = w;
        req_address = a;
        req_data = d;
        while (!req_ready && n < 60) begin
            step();
            n++;
        end
        check("accept_wait", req_ready, 1);
        step();
        acc_cyc = cyc;
        req_valid = 0;
    endtask
    task automatic drain();
        int n = 0;
        req_valid = 0;
        rsp_ready = 1;
        while (!idle && n < 100) begin
            step();
            n++;
        end
        step();
        check("drain_idle", idle, 1);
    endtask
    task automatic check_reset();
        check("rst_req_ready", req_ready, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_in_data", in_data, 0);
        check("rst_address", address, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_rsp_address", rsp_address, 0);
        check("rst_idle", idle, 1);
        check("rst_err", err_unexpected, 0);
    endtask
    initial begin
        int n;
        rst = 1;
        req_valid = 0;
        req_write = 0;
        req_address = 0;
        req_data = 0;
        rsp_ready = 0;
        valid_out = 0;
        out_data = 0;
        for (int i = 0; i < 16; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        step();
        step();
        check_reset();
        rst = 0;
        rsp_ready = 1;
        send(1, 3, 32'hDEADBEEF);
        send(0, 3, 0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        check("read_latency", cyc - acc_cyc, 4);
        check("wr_rd_data", rsp_data, 32'hDEADBEEF);
        check("wr_rd_addr", rsp_address, 3);
        drain();
        rsp_ready = 0;
        rd_pulses = 0;
        for (int i = 0; i < 4; i++)
            send(0, 4'(i), 0);
        repeat (4) step();
        check("bp_rd_pulses", rd_pulses, 2);
        drain();
        rsp_ready = 0;
        send(0, 4, 0);
        send(0, 5, 0);
        send(0, 6, 0);
        send(1, 1, 32'h1111);
        send(1, 2, 32'h2222);
        send(1, 3, 32'h3333);
        req_valid = 1;
        req_write = 1;
        req_address = 9;
        req_data = 32'h9999;
        repeat (4) step();
        check("full_hold", req_ready, 0);
        rsp_ready = 1;
        send(1, 9, 32'h9999);
        drain();
        force_vo = 1;
        repeat (3) step();
        check("spur_err", err_unexpected, 1);
        check("spur_rsp_valid", rsp_valid, 0);
        repeat (5) step();
        check("spur_sticky", err_unexpected, 1);
        send(0, 7, 0);
        step();
        check("pre_rst_rd", rd_en, 1);
        rst = 1;
        step();
        rst = 0;
        check_reset();
        repeat (4) step();
        check("post_rst_err", err_unexpected, 0);
        check("post_rst_idle", idle, 1);
        for (int i = 0; i < 600; i++) begin
            rsp_ready = $urandom_range(0, 9) < 6;
            req_valid = $urandom_range(0, 9) < 7;
            req_write = 1'($urandom);
            req_address = 4'($urandom);
            req_data = $urandom;
            step();
        end
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
